// File: rtl/perf_event_counter.sv
// perf_event_counter: in-core performance monitor. NUM_CNT programmable event
// counters plus a run-cycle counter, with freeze, clear, snapshot-to-shadow
// and an optional cycle budget that ends the run.
module perf_event_counter #(
  parameter int NUM_CNT    = 4,
  parameter int NUM_EVT    = 8,
  parameter int CNT_W      = 32,
  parameter int MAX_CYCLES = 64,
  localparam int IDX_W     = (NUM_CNT > 1) ? $clog2(NUM_CNT) : 1,
  localparam int SEL_W     = $clog2(NUM_EVT + 1)
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               start_i,
  input  logic [NUM_EVT-1:0] evt_i,
  input  logic               freeze_i,
  input  logic               clr_i,
  input  logic               snap_i,
  input  logic               cfg_we_i,
  input  logic [IDX_W-1:0]   cfg_idx_i,
  input  logic [SEL_W-1:0]   cfg_sel_i,
  input  logic               cfg_sat_i,
  input  logic [IDX_W-1:0]   rd_idx_i,
  input  logic               rd_src_i,
  output logic [CNT_W-1:0]   rd_data_o,
  output logic               rd_ovf_o,
  output logic [CNT_W-1:0]   cycle_o,
  output logic               snap_valid_o,
  output logic               done_o,
  output logic [1:0]         state_o
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'b00,
    S_RUN    = 2'b01,
    S_FROZEN = 2'b10,
    S_DONE   = 2'b11
  } state_t;

  // Event vector padded so every select code indexes a real bit; bit 0 is the
  // "disabled" slot and is tied low.
  localparam int                EXT_W    = 1 << SEL_W;
  localparam logic [CNT_W-1:0]  CNT_MAX  = '1;
  localparam logic [CNT_W-1:0]  CYC_LAST = CNT_W'(MAX_CYCLES - 1);

  state_t             state;
  logic [CNT_W-1:0]   cycle;
  logic [CNT_W-1:0]   cnt    [NUM_CNT];
  logic [CNT_W-1:0]   shadow [NUM_CNT];
  logic [SEL_W-1:0]   sel    [NUM_CNT];
  logic [NUM_CNT-1:0] sat;
  logic [NUM_CNT-1:0] ovf;
  logic [NUM_CNT-1:0] hit;
  logic [EXT_W-1:0]   evt_ext;
  logic               count_en;
  logic               budget_hit;
  logic               snap_vld;
  logic [CNT_W-1:0]   rd_live;
  logic [CNT_W-1:0]   rd_shadow;
  logic               rd_ovf;

  // Increment with end-of-range handling: all-ones either holds (saturate)
  // or rolls over to zero (wrap).
  function automatic logic [CNT_W-1:0] bump(input logic [CNT_W-1:0] v,
                                            input logic             sat_mode);
    if (v == CNT_MAX) return sat_mode ? CNT_MAX : '0;
    return v + 1'b1;
  endfunction

  // Counting is suspended in the very cycle freeze_i rises, not one later.
  assign count_en   = (state == S_RUN) && !freeze_i;
  assign budget_hit = (MAX_CYCLES != 0) && (cycle == CYC_LAST);
  assign evt_ext    = EXT_W'({evt_i, 1'b0});

  // Per-channel event hit from the currently programmed select.
  always_comb begin
    hit = '0;
    for (int c = 0; c < NUM_CNT; c++) hit[c] = evt_ext[sel[c]];
  end

  // Run-control state machine.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state <= S_IDLE;
    end else begin
      case (state)
        S_IDLE:   if (start_i) state <= S_RUN;
        S_RUN: begin
          if (freeze_i)                  state <= S_FROZEN;
          else if (!clr_i && budget_hit) state <= S_DONE;
        end
        S_FROZEN: if (!freeze_i) state <= S_RUN;
        S_DONE:   if (clr_i) state <= S_IDLE;
        default:  state <= S_IDLE;
      endcase
    end
  end

  // Run-cycle counter; wraps silently, stops outside RUN.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i)        cycle <= '0;
    else if (clr_i)    cycle <= '0;
    else if (count_en) cycle <= cycle + 1'b1;
  end

  // Channel configuration; an out-of-range index matches no channel.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      for (int c = 0; c < NUM_CNT; c++) sel[c] <= '0;
      sat <= '0;
    end else begin
      for (int c = 0; c < NUM_CNT; c++) begin
        if (cfg_we_i && (cfg_idx_i == IDX_W'(c))) begin
          sel[c] <= cfg_sel_i;
          sat[c] <= cfg_sat_i;
        end
      end
    end
  end

  // Live counters and sticky overflow; clear wins over a same-cycle event.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      for (int c = 0; c < NUM_CNT; c++) cnt[c] <= '0;
      ovf <= '0;
    end else begin
      for (int c = 0; c < NUM_CNT; c++) begin
        if (clr_i) begin
          cnt[c] <= '0;
          ovf[c] <= 1'b0;
        end else if (count_en && hit[c]) begin
          cnt[c] <= bump(cnt[c], sat[c]);
          if (cnt[c] == CNT_MAX) ovf[c] <= 1'b1;
        end
      end
    end
  end

  // Shadow capture of pre-edge counter values, with a one-cycle valid pulse.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      for (int c = 0; c < NUM_CNT; c++) shadow[c] <= '0;
      snap_vld <= 1'b0;
    end else begin
      for (int c = 0; c < NUM_CNT; c++) begin
        if (snap_i) shadow[c] <= cnt[c];
      end
      snap_vld <= snap_i;
    end
  end

  // Read mux; an index with no channel behind it reads as zero.
  always_comb begin
    rd_live   = '0;
    rd_shadow = '0;
    rd_ovf    = 1'b0;
    for (int c = 0; c < NUM_CNT; c++) begin
      if (rd_idx_i == IDX_W'(c)) begin
        rd_live   = cnt[c];
        rd_shadow = shadow[c];
        rd_ovf    = ovf[c];
      end
    end
  end

  // Registered read port, one cycle of latency.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      rd_data_o <= '0;
      rd_ovf_o  <= 1'b0;
    end else begin
      rd_data_o <= rd_src_i ? rd_shadow : rd_live;
      rd_ovf_o  <= rd_ovf;
    end
  end

  assign cycle_o      = cycle;
  assign snap_valid_o = snap_vld;
  assign done_o       = (state == S_DONE);
  assign state_o      = state;

endmodule
